scan_sel_gen: RTL and testbench

SCAN_SEL_GEN -- requirements
Module: scan_sel_gen

---
 rtl/scan_sel_gen.sv | 96 +++++++++
 tb/tb_scan_sel_gen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/scan_sel_gen.sv
// 2-bit select generator driving a 2-to-4 decoder: free-running prescaled
// advance, single-step on step rising edge, synchronous load, tick/wrap pulses.
module scan_sel_gen #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mode,
  input  logic       dir,
  input  logic       step,
  input  logic       load,
  input  logic [1:0] load_val,
  output logic       a,
  output logic       b,
  output logic       tick,
  output logic       wrap
);

  localparam int unsigned PCNT_W = 16;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_e;

  state_e              state_q;
  state_e              state_d;
  logic [PCNT_W-1:0]   pcnt_q;
  logic [PCNT_W-1:0]   pcnt_base_c;
  logic [1:0]          sel_q;
  logic [1:0]          sel_nxt_c;
  logic                step_q;
  logic                tick_q;
  logic                wrap_q;
  logic                adv_c;
  logic                wrap_c;

  // State is re-derived every cycle from en/mode; the decision for this edge uses it.
  // A count only continues if the previous cycle was also RUN, so RUN entry starts fresh.
  always_comb begin
    state_d     = IDLE;
    adv_c       = 1'b0;
    pcnt_base_c = (state_q == RUN) ? pcnt_q : '0;
    sel_nxt_c   = dir ? (sel_q - 2'd1) : (sel_q + 2'd1);
    wrap_c      = dir ? (sel_q == 2'd0) : (sel_q == 2'd3);
    if (en) begin
      state_d = mode ? STEP : RUN;
    end
    case (state_d)
      RUN:     adv_c = (pcnt_base_c == PCNT_LAST);
      STEP:    adv_c = step & ~step_q;
      default: adv_c = 1'b0;
    endcase
  end

  // Load overrides any advance and clears the prescaler.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      pcnt_q  <= '0;
      step_q  <= 1'b0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      if (load) begin
        sel_q  <= load_val;
        pcnt_q <= '0;
      end else begin
        if (state_d == RUN) begin
          pcnt_q <= adv_c ? '0 : (pcnt_base_c + PCNT_W'(1));
        end else begin
          pcnt_q <= '0;
        end
        if (adv_c) begin
          sel_q  <= sel_nxt_c;
          tick_q <= 1'b1;
          wrap_q <= wrap_c;
        end
      end
    end
  end

  assign a    = sel_q[1];
  assign b    = sel_q[0];
  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Bench for scan_sel_gen: directed stimulus queues expected advances (cycle, sel, wrap);
// a negedge monitor pops one entry per tick and compares.
module tb_scan_sel_gen;

  localparam int unsigned PRESCALE = 4;

  logic       clk = 1'b0;
  logic       rst_n, en, mode, dir, step, load;
  logic [1:0] load_val;
  logic       a, b, tick, wrap;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    int sel;
    int wrap;
  } exp_t;

  exp_t exp_q[$];

  scan_sel_gen #(.PRESCALE(PRESCALE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .step     (step),
    .load     (load),
    .load_val (load_val),
    .a        (a),
    .b        (b),
    .tick     (tick),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expect an advance to sel s (with wrap w) to become visible dly edges from now.
  task automatic expect_adv(input int s, input int w, input int dly);
    exp_t e;
    e.cyc  = cyc + dly;
    e.sel  = s;
    e.wrap = w;
    exp_q.push_back(e);
  endtask

  task automatic tickn(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every tick must match the oldest expected advance.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (tick === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick: sel=%0d at cycle %0d, expected no tick", int'({a, b}), cyc);
      end else begin
        e = exp_q.pop_front();
        chk("adv_cycle", cyc, e.cyc);
        chk("adv_sel", int'({a, b}), e.sel);
        chk("adv_wrap", int'(wrap), e.wrap);
      end
    end else if (wrap !== 1'b0 && rst_n === 1'b1 && cyc > 2) begin
      chk("wrap_without_tick", int'(wrap), 0);
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; dir = 1'b0;
    step = 1'b0; load = 1'b0; load_val = 2'd0;
    tickn(2);
    chk("rst_a", int'(a), 0);
    chk("rst_b", int'(b), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_wrap", int'(wrap), 0);

    // Free-run up count from reset
    rst_n = 1'b1; en = 1'b1;
    expect_adv(1, 0, 4);
    expect_adv(2, 0, 8);
    expect_adv(3, 0, 12);
    expect_adv(0, 1, 16);
    tickn(16);
    en = 1'b0;
    tickn(2);

    // Down count from 0 wraps to 3
    dir = 1'b1; en = 1'b1;
    expect_adv(3, 1, 4);
    tickn(4);
    en = 1'b0; dir = 1'b0;
    tickn(2);

    // Load in IDLE, then single-step: long high, then two pulses
    load = 1'b1; load_val = 2'd0;
    tickn(1);
    load = 1'b0;
    chk("load_idle_sel", int'({a, b}), 0);
    en = 1'b1; mode = 1'b1; step = 1'b1;
    expect_adv(1, 0, 1);
    tickn(10);
    step = 1'b0;
    tickn(3);
    step = 1'b1;
    expect_adv(2, 0, 1);
    tickn(1);
    step = 1'b0;
    tickn(2);
    step = 1'b1;
    expect_adv(3, 0, 1);
    tickn(1);
    step = 1'b0;
    tickn(3);
    chk("step_sel", int'({a, b}), 3);

    // Load on the cycle the prescaler would fire
    mode = 1'b0;
    tickn(3);
    load = 1'b1; load_val = 2'd2;
    tickn(1);
    load = 1'b0;
    chk("load_sel", int'({a, b}), 2);
    chk("load_tick", int'(tick), 0);
    expect_adv(3, 0, 4);
    expect_adv(0, 1, 8);
    expect_adv(1, 0, 12);
    tickn(12);

    // Pause at sel=1; step toggles in IDLE are ignored
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step = i[0];
      tickn(1);
    end
    step = 1'b0;
    chk("pause_sel", int'({a, b}), 1);
    chk("pause_tick", int'(tick), 0);
    en = 1'b1;
    expect_adv(2, 0, 4);
    expect_adv(3, 0, 8);
    tickn(10);

    // Reset at sel=3, pcnt=2
    rst_n = 1'b0;
    tickn(1);
    rst_n = 1'b1;
    chk("midrst_sel", int'({a, b}), 0);
    chk("midrst_tick", int'(tick), 0);
    chk("midrst_wrap", int'(wrap), 0);
    expect_adv(1, 0, 4);
    tickn(4);
    en = 1'b0;
    tickn(2);

    // step already high on first STEP cycle after reset counts as an edge
    rst_n = 1'b0; en = 1'b1; mode = 1'b1; step = 1'b1;
    tickn(2);
    rst_n = 1'b1;
    expect_adv(1, 0, 1);
    tickn(2);
    step = 1'b0; en = 1'b0;
    tickn(2);

    chk("pending_expectations", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
